// File: rtl/branch_history_table_gshare.sv
// gshare BHT: saturating counters with combinational lookups; lookup 0 cycles, update 1 cycle, no backpressure.
// Updates are dropped while busy_o is high. Define BHT_GSHARE_GHR_EN to add the global history register to indexing.
module branch_history_table_gshare #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned NR_LOOKUP  = 2,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 6,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             debug_mode_i,
  input  logic                             fb_valid_i,
  input  logic                             fb_branch_taken_i,
  input  logic [ADDR_W-1:0]                fb_branch_pc_i,
  input  logic [NR_LOOKUP-1:0][ADDR_W-1:0] branch_pc_i,
  output logic [NR_LOOKUP-1:0]             predict_valid_o,
  output logic [NR_LOOKUP-1:0]             predict_taken_o,
  output logic                             busy_o,
  output logic [GHR_BITS-1:0]              ghr_o
);
  localparam int unsigned IDX    = $clog2(NR_ENTRIES);
  localparam int unsigned OFFSET = 2;
  localparam int unsigned PTR_W  = IDX + 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(NR_ENTRIES - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [NR_ENTRIES-1:0] valid_q;
  logic [CTR_BITS-1:0]   ctr_q [NR_ENTRIES];

  logic [IDX-1:0]        ghr_ext;
  logic                  upd_en;
  logic [IDX-1:0]        upd_idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_nxt;
  logic [IDX-1:0]        lk_idx [NR_LOOKUP];
  logic                  unused_pc_bits;

  assign busy_o = (state_q == CLEAR);

  // A flush in the same cycle always wins over a resolved-branch update.
  assign upd_en  = (state_q == IDLE) && fb_valid_i && !debug_mode_i && !flush_i;
  assign upd_idx = fb_branch_pc_i[OFFSET +: IDX] ^ ghr_ext;
  assign upd_cur = ctr_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (fb_branch_taken_i) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_BITS'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CTR_BITS'(1);
    end
  end

`ifdef BHT_GSHARE_GHR_EN
  logic [GHR_BITS-1:0] ghr_q;

  // Truncating cast yields {ghr[GHR_BITS-2:0], taken}, which also covers GHR_BITS == 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else if (flush_i) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= GHR_BITS'({ghr_q, fb_branch_taken_i});
    end
  end

  assign ghr_ext = IDX'(ghr_q);
  assign ghr_o   = ghr_q;
`else
  assign ghr_ext = '0;
  assign ghr_o   = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end else if (upd_en) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= upd_nxt;
          end
        end
        CLEAR: begin
          valid_q[ptr_q[IDX-1:0]] <= 1'b0;
          ctr_q[ptr_q[IDX-1:0]]   <= CTR_INIT;
          if (flush_i) begin
            ptr_q <= '0;
          end else if (ptr_q == PTR_LAST) begin
            state_q <= IDLE;
          end else begin
            ptr_q <= ptr_q + PTR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Predictions read the registered table; during the sweep they are forced to not-valid/not-taken.
  always_comb begin
    predict_valid_o = '0;
    predict_taken_o = '0;
    for (int i = 0; i < NR_LOOKUP; i++) begin
      lk_idx[i] = branch_pc_i[i][OFFSET +: IDX] ^ ghr_ext;
      if (state_q == IDLE) begin
        predict_valid_o[i] = valid_q[lk_idx[i]];
        predict_taken_o[i] = ctr_q[lk_idx[i]][CTR_BITS-1];
      end
    end
  end

  assign unused_pc_bits = ^{fb_branch_pc_i, branch_pc_i};

endmodule

// File: tb/tb_branch_history_table_gshare.sv
// Scoreboard bench for branch_history_table_gshare: stimulus queues expectations, a negedge monitor checks them.
module tb_branch_history_table_gshare;
  localparam int unsigned NL = 2;
  localparam int unsigned GB = 2;
  localparam int unsigned AW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 dbg;
  logic                 fb_v;
  logic                 fb_t;
  logic [AW-1:0]        fb_pc;
  logic [NL-1:0][AW-1:0] lk_pc;
  logic [NL-1:0]        pv;
  logic [NL-1:0]        pt;
  logic                 busy;
  logic [GB-1:0]        ghr;

  always #5 clk = ~clk;

  branch_history_table_gshare #(
    .NR_ENTRIES(64),
    .NR_LOOKUP (NL),
    .CTR_BITS  (2),
    .GHR_BITS  (GB),
    .ADDR_W    (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .debug_mode_i     (dbg),
    .fb_valid_i       (fb_v),
    .fb_branch_taken_i(fb_t),
    .fb_branch_pc_i   (fb_pc),
    .branch_pc_i      (lk_pc),
    .predict_valid_o  (pv),
    .predict_taken_o  (pt),
    .busy_o           (busy),
    .ghr_o            (ghr)
  );

  typedef struct {
    string      name;
    logic [1:0] pv;
    logic [1:0] pt;
    logic       busy;
    logic [1:0] ghr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: everything queued during the current cycle is compared half a period after the edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if ({pv, pt, busy, ghr} !== {mon_e.pv, mon_e.pt, mon_e.busy, mon_e.ghr}) begin
        n_errors++;
        $display("FAIL %s: got pv=%b pt=%b busy=%b ghr=%b, want pv=%b pt=%b busy=%b ghr=%b",
                 mon_e.name, pv, pt, busy, ghr, mon_e.pv, mon_e.pt, mon_e.busy, mon_e.ghr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [1:0] v, input logic [1:0] t,
                     input logic b, input logic [1:0] g);
    exp_t e;
    e.name = n; e.pv = v; e.pt = t; e.busy = b; e.ghr = g;
    sb.push_back(e);
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic tk);
    fb_v  = 1'b1;
    fb_pc = pc;
    fb_t  = tk;
    tick();
    fb_v  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dbg = 1'b0; fb_v = 1'b0; fb_t = 1'b0; fb_pc = '0;
    lk_pc[0] = 32'h8000_0010;
    lk_pc[1] = 32'h8000_0100;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset", 2'b00, 2'b11, 1'b0, 2'b00);

`ifndef BHT_GSHARE_GHR_EN
    // Entry 4 walks 10->01->00->00, then up to saturation at 11 and back down.
    upd(32'h8000_0010, 1'b0); chk("nt1", 2'b01, 2'b10, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b0); chk("nt2", 2'b01, 2'b10, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b0); chk("nt3_sat0", 2'b01, 2'b10, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b1); chk("t1", 2'b01, 2'b10, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b1); chk("t2", 2'b01, 2'b11, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b1); chk("t3", 2'b01, 2'b11, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b1); chk("t4_sat3", 2'b01, 2'b11, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b0); chk("nt_from_sat", 2'b01, 2'b11, 1'b0, 2'b00);
    upd(32'h8000_0010, 1'b0); chk("nt_to_01", 2'b01, 2'b10, 1'b0, 2'b00);
`else
    lk_pc[0] = 32'h0; lk_pc[1] = 32'h4;
    chk("g_reset", 2'b00, 2'b11, 1'b0, 2'b00);
    upd(32'h0, 1'b1);  chk("g_upd0", 2'b10, 2'b11, 1'b0, 2'b01);
    upd(32'h4, 1'b1);  chk("g_upd1", 2'b00, 2'b11, 1'b0, 2'b11);
    lk_pc[0] = 32'hC;  chk("g_entry0", 2'b01, 2'b11, 1'b0, 2'b11);
    upd(32'hC, 1'b0);  lk_pc[0] = 32'h8;
    chk("g_nt1", 2'b01, 2'b11, 1'b0, 2'b10);
    upd(32'h8, 1'b0);  lk_pc[0] = 32'h0;
    chk("g_nt2", 2'b01, 2'b10, 1'b0, 2'b00);
    upd(32'h100, 1'b1);
    chk("g_preflush", 2'b10, 2'b11, 1'b0, 2'b01);
`endif

    // Single flush: 64 busy cycles, update at cycle 10 dropped.
    lk_pc[0] = 32'h8000_0010; lk_pc[1] = 32'h0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      chk("flush_busy", 2'b00, 2'b00, 1'b1, 2'b00);
      if (k == 10) begin fb_v = 1'b1; fb_pc = 32'h8000_0010; fb_t = 1'b1; end
      tick();
      fb_v = 1'b0;
    end
    chk("flush_done", 2'b00, 2'b11, 1'b0, 2'b00);

    // Retrigger at sweep cycle 30: busy through cycle 94.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 1; k <= 94; k++) begin
      chk("retrig_busy", 2'b00, 2'b00, 1'b1, 2'b00);
      if (k == 30) flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    chk("retrig_done", 2'b00, 2'b11, 1'b0, 2'b00);

    // Flush and update together: flush wins.
    flush = 1'b1; fb_v = 1'b1; fb_pc = 32'h8000_0010; fb_t = 1'b0;
    tick();
    flush = 1'b0; fb_v = 1'b0;
    chk("collide_busy", 2'b00, 2'b00, 1'b1, 2'b00);
    repeat (64) tick();
    chk("collide_done", 2'b00, 2'b11, 1'b0, 2'b00);

    // Debug mode blocks table and history; then a normal update, old value visible in its own cycle.
    dbg = 1'b1;
    upd(32'h8000_0010, 1'b1);
    dbg = 1'b0;
    chk("debug_hold", 2'b00, 2'b11, 1'b0, 2'b00);
    fb_v = 1'b1; fb_pc = 32'h8000_0010; fb_t = 1'b0;
    chk("upd_old_visible", 2'b00, 2'b11, 1'b0, 2'b00);
    tick();
    fb_v = 1'b0;
    chk("upd_new", 2'b01, 2'b10, 1'b0, 2'b00);

    // Reset between edges during a sweep must drop busy before the next edge.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("pre_rst_busy", 2'b00, 2'b00, 1'b1, 2'b00);
      tick();
    end
    rst = 1'b1;
    chk("async_rst", 2'b00, 2'b11, 1'b0, 2'b00);
    tick();
    rst = 1'b0;
    chk("post_rst", 2'b00, 2'b11, 1'b0, 2'b00);
    tick();

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
